dff_bank_arbiter: RTL and testbench

- Controller that shares one WIDTH-bit D-flip-flop storage bank between NREQ requesters.
- Grants ownership round-robin with a req/gnt handshake and bounded hold time.
- Generates the bank's data, load-enable and active-low clear controls.
- Sits between requester blocks and the dff bank; the bank itself is external.

---
 rtl/dff_bank_pkg.sv | 16 +
 rtl/dff_bank_arbiter_rr_pick.sv | 40 ++++
 rtl/dff_bank_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dff_bank_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/dff_bank_pkg.sv
// Shared definitions for the dff bank arbiter.
// Holds the FSM state encoding and the hold-counter width rule.
package dff_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // Hold counter only has to reach MAX_HOLD-1, so clog2(MAX_HOLD) bits suffice.
  function automatic int cnt_w(input int max_hold);
    return (max_hold < 2) ? 1 : $clog2(max_hold);
  endfunction

endpackage

// File: rtl/dff_bank_arbiter_rr_pick.sv
// Combinational round-robin priority picker.
// Ports:
//   eligible : per-requester eligibility
//   ptr      : index with highest priority this round
//   choice   : one-hot winner (0 when nothing eligible)
//   idx      : winner index
//   valid    : some requester was eligible
module rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] choice,
  output logic [PW-1:0]   idx,
  output logic            valid
);

  logic [PW:0] tgt;

  // Walk candidates ptr, ptr+1, ... (mod NREQ); the first eligible one wins.
  always_comb begin
    choice = '0;
    idx    = '0;
    valid  = 1'b0;
    tgt    = '0;
    for (int k = 0; k < NREQ; k++) begin
      tgt = {1'b0, ptr} + (PW+1)'(k);
      if (tgt >= (PW+1)'(NREQ)) tgt = tgt - (PW+1)'(NREQ);
      for (int i = 0; i < NREQ; i++) begin
        if (!valid && eligible[i] && (tgt == (PW+1)'(i))) begin
          valid     = 1'b1;
          choice[i] = 1'b1;
          idx       = PW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Shares one WIDTH-bit dff bank between NREQ requesters.
// Round-robin req/gnt handshake with bounded hold time; drives the bank's
// data, load enable and active-low clear.
// Ports:
//   clock, clear      : clock and synchronous active-high reset
//   req/wr/clr        : per-requester request, write strobe, clear strobe
//   wdata             : packed requester data, slice i = wdata[i*WIDTH +: WIDTH]
//   gnt               : registered one-hot grant
//   bank_d/bank_load  : registered bank data and one-cycle load enable
//   bank_clear_n      : registered active-low bank clear
//   timeout           : one-cycle pulse on forced release
//   busy              : FSM not in IDLE
module dff_bank_arbiter
  import dff_bank_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       wr,
  input  logic [NREQ-1:0]       clr,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      bank_d,
  output logic                  bank_load,
  output logic                  bank_clear_n,
  output logic                  timeout,
  output logic                  busy
);

  localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = cnt_w(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [PW-1:0]    PTR_LAST = PW'(NREQ - 1);

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NREQ-1:0]   lock_q, lock_d;
  logic [WIDTH-1:0]  bank_d_q, bank_d_d;
  logic              load_q, load_d;
  logic              clear_n_q, clear_n_d;
  logic              timeout_q, timeout_d;

  logic [NREQ-1:0]   pick_onehot;
  logic [PW-1:0]     pick_idx;
  logic              pick_valid;
  logic              owner_req, owner_wr, owner_clr;
  logic [WIDTH-1:0]  owner_wdata;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .eligible (req & ~lock_q),
    .ptr      (ptr_q),
    .choice   (pick_onehot),
    .idx      (pick_idx),
    .valid    (pick_valid)
  );

  // gnt_q is one-hot in GRANT and zero elsewhere, so masking with it
  // selects the owner's strobes and data and ignores everyone else.
  always_comb begin
    owner_req   = |(req & gnt_q);
    owner_wr    = |(wr  & gnt_q);
    owner_clr   = |(clr & gnt_q);
    owner_wdata = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt_q[i]) owner_wdata = owner_wdata | wdata[i*WIDTH +: WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    lock_d    = lock_q & req;   // lockout bit drops once its req is seen low
    bank_d_d  = bank_d_q;
    load_d    = 1'b0;
    clear_n_d = 1'b1;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (pick_valid) begin
          state_d = ST_GRANT;
          gnt_d   = pick_onehot;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        cnt_d = cnt_q + 1'b1;
        // clr beats wr; a write in the cycle req drops is not honoured
        if (owner_clr) begin
          clear_n_d = 1'b0;
        end else if (owner_wr && owner_req) begin
          load_d   = 1'b1;
          bank_d_d = owner_wdata;
        end
        if (!owner_req) begin
          state_d = ST_RELEASE;
          gnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_RELEASE;
          gnt_d     = '0;
          timeout_d = 1'b1;
          lock_d    = lock_d | gnt_q;
        end
      end
      ST_RELEASE: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
        ptr_d   = (owner_q == PTR_LAST) ? '0 : owner_q + 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      lock_q    <= '0;
      bank_d_q  <= '0;
      load_q    <= 1'b0;
      clear_n_q <= 1'b0;   // bank held cleared while reset is asserted
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      lock_q    <= lock_d;
      bank_d_q  <= bank_d_d;
      load_q    <= load_d;
      clear_n_q <= clear_n_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt          = gnt_q;
  assign bank_d       = bank_d_q;
  assign bank_load    = load_q;
  assign bank_clear_n = clear_n_q;
  assign timeout      = timeout_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter (NREQ=2, WIDTH=8, MAX_HOLD=4).
module tb_dff_bank_arbiter;

  logic        clock = 1'b0;
  logic        clear;
  logic [1:0]  req, wr, clr;
  logic [15:0] wdata;
  logic [1:0]  gnt;
  logic [7:0]  bank_d;
  logic        bank_load, bank_clear_n, timeout, busy;

  int n_cmp  = 0;
  int n_fail = 0;

  dff_bank_arbiter #(.NREQ(2), .WIDTH(8), .MAX_HOLD(4)) dut (
    .clock        (clock),
    .clear        (clear),
    .req          (req),
    .wr           (wr),
    .clr          (clr),
    .wdata        (wdata),
    .gnt          (gnt),
    .bank_d       (bank_d),
    .bank_load    (bank_load),
    .bank_clear_n (bank_clear_n),
    .timeout      (timeout),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    clear = 1'b1; req = 2'b11; wr = 2'b00; clr = 2'b00; wdata = 16'h0000;

    // reset held for three edges with both requesting
    tick();
    chk("rst1_gnt", gnt, 2'b00);
    chk("rst1_clrn", bank_clear_n, 1'b0);
    tick(); tick();
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_clrn", bank_clear_n, 1'b0);
    chk("rst_load", bank_load, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tmo", timeout, 1'b0);
    chk("rst_bankd", bank_d, 8'h00);

    clear = 1'b0;
    tick();
    chk("post_rst_clrn", bank_clear_n, 1'b1);
    chk("first_gnt", gnt, 2'b01);
    chk("first_busy", busy, 1'b1);

    // single write
    req = 2'b01; wr = 2'b01; wdata = 16'h00A5;
    tick();
    chk("wr_load", bank_load, 1'b1);
    chk("wr_bankd", bank_d, 8'hA5);
    wr = 2'b00;
    tick();
    chk("wr_load_off", bank_load, 1'b0);
    chk("wr_bankd_hold", bank_d, 8'hA5);
    chk("wr_gnt_hold", gnt, 2'b01);

    // clr beats wr
    wr = 2'b01; clr = 2'b01; wdata = 16'h003C;
    tick();
    chk("clrpri_clrn", bank_clear_n, 1'b0);
    chk("clrpri_load", bank_load, 1'b0);
    chk("clrpri_bankd", bank_d, 8'hA5);

    // req drops with a write: write ignored, release
    clr = 2'b00; wr = 2'b01; wdata = 16'h0011; req = 2'b00;
    tick();
    chk("rel_clrn", bank_clear_n, 1'b1);
    chk("rel_load", bank_load, 1'b0);
    chk("rel_bankd", bank_d, 8'hA5);
    chk("rel_gnt", gnt, 2'b00);
    chk("rel_tmo", timeout, 1'b0);
    chk("rel_busy", busy, 1'b1);
    wr = 2'b00;
    tick();
    chk("idle_gnt", gnt, 2'b00);
    chk("idle_busy", busy, 1'b0);

    // round robin: pointer now at 1
    req = 2'b11;
    tick();
    chk("rr_gnt1", gnt, 2'b10);
    tick(); tick();
    chk("rr_gnt1_hold", gnt, 2'b10);
    req = 2'b01;
    tick();
    chk("rr_rel1", gnt, 2'b00);
    req = 2'b11;
    tick();
    chk("rr_idle1", gnt, 2'b00);
    tick();
    chk("rr_gnt0", gnt, 2'b01);
    tick(); tick();
    req = 2'b10;
    tick();
    chk("rr_rel0", gnt, 2'b00);
    req = 2'b11;
    tick();
    chk("rr_idle0", gnt, 2'b00);

    // timeout: owner 1 holds req
    tick();
    chk("to_gnt_c0", gnt, 2'b10);
    chk("to_tmo_c0", timeout, 1'b0);
    tick(); tick(); tick();
    chk("to_gnt_c3", gnt, 2'b10);
    chk("to_tmo_c3", timeout, 1'b0);
    tick();
    chk("to_tmo", timeout, 1'b1);
    chk("to_gnt_off", gnt, 2'b00);
    tick();
    chk("to_tmo_pulse", timeout, 1'b0);
    chk("to_idle_busy", busy, 1'b0);
    tick();
    chk("to_other_gnt", gnt, 2'b01);

    // non-owner strobes ignored
    wr = 2'b10; clr = 2'b10; wdata = 16'hFF00;
    tick();
    chk("ign_load", bank_load, 1'b0);
    chk("ign_clrn", bank_clear_n, 1'b1);
    chk("ign_bankd", bank_d, 8'hA5);
    chk("ign_gnt", gnt, 2'b01);

    // locked-out requester 1 not re-granted until req drops
    wr = 2'b00; clr = 2'b00; req = 2'b10;
    tick();
    chk("lk_rel", gnt, 2'b00);
    tick(); tick();
    chk("lk_blocked", gnt, 2'b00);
    chk("lk_busy", busy, 1'b0);
    req = 2'b00;
    tick();
    req = 2'b10;
    tick();
    chk("lk_regrant", gnt, 2'b10);

    // reset mid-grant drops the pending load
    wr = 2'b10; wdata = 16'h7700; clear = 1'b1;
    tick();
    chk("mid_rst_gnt", gnt, 2'b00);
    chk("mid_rst_load", bank_load, 1'b0);
    chk("mid_rst_clrn", bank_clear_n, 1'b0);
    chk("mid_rst_bankd", bank_d, 8'h00);
    chk("mid_rst_busy", busy, 1'b0);
    clear = 1'b0; wr = 2'b00; req = 2'b00;
    tick();
    chk("mid_rst_clrn_up", bank_clear_n, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
